// File: rtl/scoreboard_register_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard_register_file_if
//  Description : Decode/writeback-side bundle for the scoreboarded register
//                file. It carries the two read ports with their busy flags,
//                the reserve strobe, the writeback strobe and the ready flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface scoreboard_register_file_if #(
    parameter  int XLEN     = 32,
    parameter  int NUM_REGS = 32,
    localparam int AW       = $clog2(NUM_REGS)
);
    logic            ready;
    logic [AW-1:0]   read_addr1;
    logic [XLEN-1:0] read_data1;
    logic            read_busy1;
    logic [AW-1:0]   read_addr2;
    logic [XLEN-1:0] read_data2;
    logic            read_busy2;
    logic            reserve_en;
    logic [AW-1:0]   reserve_addr;
    logic            write_en;
    logic [AW-1:0]   write_addr;
    logic [XLEN-1:0] write_data;

    // Pipeline side: issues addresses and strobes, consumes data and busy.
    modport master (
        input  ready,
        output read_addr1, input read_data1, input read_busy1,
        output read_addr2, input read_data2, input read_busy2,
        output reserve_en, output reserve_addr,
        output write_en, output write_addr, output write_data
    );

    // Register file side.
    modport slave (
        output ready,
        input  read_addr1, output read_data1, output read_busy1,
        input  read_addr2, output read_data2, output read_busy2,
        input  reserve_en, input reserve_addr,
        input  write_en, input write_addr, input write_data
    );
endinterface
`default_nettype wire

// File: rtl/scoreboard_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard_register_file
//  Description : XLEN x NUM_REGS architectural register file with two
//                combinational read ports, one synchronous write port and a
//                busy bit per entry for hazard detection. After every reset
//                a sequential engine zeroes one entry per cycle; the file is
//                opaque (reads 0, strobes ignored) until ready rises.
//                Optional macro REGFILE_BYPASS_EN forwards the same-cycle
//                writeback value to the read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_register_file #(
    parameter  int XLEN     = 32,
    parameter  int NUM_REGS = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    scoreboard_register_file_if.slave   bus
);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_LAST_IDX = AW'(NUM_REGS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_idx;
    logic            r_ready;
    logic [XLEN-1:0] r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;

    logic            w_wr_ok;
    logic            w_rsv_ok;
    logic [XLEN:0]   w_rd1;
    logic [XLEN:0]   w_rd2;

    // Zero-extend before comparing so a power-of-two depth does not produce a
    // constant comparison on the narrow address.
    function automatic logic f_in_range(input logic [AW-1:0] a);
        return (32'(a) < 32'(NUM_REGS));
    endfunction

    // Address is a real, writable register (not x0, not past the end).
    function automatic logic f_valid_dst(input logic [AW-1:0] a);
        return (a != '0) && f_in_range(a);
    endfunction

    // Read port value packed as {busy, data}.
    function automatic logic [XLEN:0] f_read(input logic [AW-1:0] a);
        logic [XLEN:0] v;
        v = '0;
        if (r_ready && f_valid_dst(a)) begin
`ifdef REGFILE_BYPASS_EN
            if (w_wr_ok && (a == bus.write_addr))
                v = {w_rsv_ok && (bus.reserve_addr == a), bus.write_data};
            else
`endif
                v = {r_busy[a], r_mem[a]};
        end
        return v;
    endfunction

    // Strobes only take effect once the clear sweep has finished.
    always_comb begin
        w_wr_ok  = r_ready && bus.write_en   && f_valid_dst(bus.write_addr);
        w_rsv_ok = r_ready && bus.reserve_en && f_valid_dst(bus.reserve_addr);
    end

    // Next-state: sweep every index once, then stay in RUN until reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_idx == c_LAST_IDX) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // State, clear index and ready flag; ready trails the RUN state by one
    // cycle so it rises NUM_REGS cycles after the first non-reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= (r_state == S_CLEAR) ? r_clr_idx + 1'b1 : '0;
            r_ready   <= (r_state == S_RUN);
        end
    end

    // Data array: the clear engine owns it in CLEAR, writeback owns it after.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_CLEAR)
                r_mem[r_clr_idx] <= '0;
            else if (w_wr_ok)
                r_mem[bus.write_addr] <= bus.write_data;
        end
    end

    // Busy bits: writeback releases, reserve claims; reserve is applied last
    // so a same-cycle reserve of the written register leaves it busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                r_busy[r_clr_idx] <= 1'b0;
            end else begin
                if (w_wr_ok)
                    r_busy[bus.write_addr] <= 1'b0;
                if (w_rsv_ok)
                    r_busy[bus.reserve_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports.
    always_comb begin
        w_rd1 = f_read(bus.read_addr1);
        w_rd2 = f_read(bus.read_addr2);
    end

    assign bus.read_data1 = w_rd1[XLEN-1:0];
    assign bus.read_busy1 = w_rd1[XLEN];
    assign bus.read_data2 = w_rd2[XLEN-1:0];
    assign bus.read_busy2 = w_rd2[XLEN];
    assign bus.ready      = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scoreboard_register_file
//  Description : Self-checking bench for scoreboard_register_file. Directed
//                scenarios plus randomized traffic are compared against an
//                array-based reference model of the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scoreboard_register_file;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int AW       = $clog2(NUM_REGS);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scoreboard_register_file_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) bus ();

    scoreboard_register_file #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state.
    logic [XLEN-1:0] m_mem  [NUM_REGS];
    bit              m_busy [NUM_REGS];
    int              m_cnt;
    bit              m_ready;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN:0] model_read(input logic [AW-1:0] a);
        if (!m_ready || a == '0 || int'(a) >= NUM_REGS) return '0;
`ifdef REGFILE_BYPASS_EN
        if (bus.write_en && bus.write_addr != '0 && bus.write_addr == a)
            return {bus.reserve_en && bus.reserve_addr == a, bus.write_data};
`endif
        return {m_busy[a], m_mem[a]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // One clock: drive, check reads before the edge, step the model, check ready.
    task automatic cyc(input logic rst, input logic we, input logic [AW-1:0] wa,
                       input logic [XLEN-1:0] wd, input logic re, input logic [AW-1:0] ra,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        reset            = rst;
        bus.write_en     = we;
        bus.write_addr   = wa;
        bus.write_data   = wd;
        bus.reserve_en   = re;
        bus.reserve_addr = ra;
        bus.read_addr1   = a1;
        bus.read_addr2   = a2;
        #2;
        check("rd1", {31'd0, bus.read_busy1, bus.read_data1}, {31'd0, model_read(a1)});
        check("rd2", {31'd0, bus.read_busy2, bus.read_data2}, {31'd0, model_read(a2)});
        @(posedge clk);
        if (rst) begin
            model_clear();
            m_cnt = 0;
        end else begin
            if (m_ready) begin
                if (we && wa != '0) begin
                    m_mem[wa]  = wd;
                    m_busy[wa] = 1'b0;
                end
                if (re && ra != '0) m_busy[ra] = 1'b1;
            end
            m_cnt++;
        end
        m_ready = (m_cnt > NUM_REGS);
        #1;
        check("ready", {63'd0, bus.ready}, {63'd0, m_ready});
    endtask

    task automatic idle(input logic rst);
        cyc(rst, 1'b0, '0, '0, 1'b0, '0,
            AW'($urandom_range(0, NUM_REGS - 1)), AW'($urandom_range(0, NUM_REGS - 1)));
    endtask

    task automatic cyc_rand(input logic rst);
        logic [AW-1:0] wa, a1, a2;
        wa = AW'($urandom_range(0, NUM_REGS - 1));
        a1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, NUM_REGS - 1));
        a2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NUM_REGS - 1));
        cyc(rst, 1'($urandom_range(0, 1)), wa, $urandom,
            1'($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NUM_REGS - 1)),
            a1, a2);
    endtask

    initial begin
        m_cnt   = 0;
        m_ready = 1'b0;
        model_clear();
        reset = 1'b1;
        bus.write_en = 1'b0; bus.write_addr = '0; bus.write_data = '0;
        bus.reserve_en = 1'b0; bus.reserve_addr = '0;
        bus.read_addr1 = '0; bus.read_addr2 = '0;

        // Reset two cycles, then the clear sweep: ready low for 32 edges.
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        check("t1_reset_ready", {63'd0, bus.ready}, 64'd0);
        for (int i = 0; i < NUM_REGS; i++) idle(1'b0);
        check("t1_still_low", {63'd0, bus.ready}, 64'd0);
        idle(1'b0);
        check("t1_ready_high", {63'd0, bus.ready}, 64'd1);

        // Write x5, read it back; x0 stays zero.
        cyc(1'b0, 1'b1, AW'(5), 32'hDEADBEEF, 1'b0, '0, AW'(5), AW'(5));
        check("t2_x5", {32'd0, bus.read_data1}, 64'hDEADBEEF);
        cyc(1'b0, 1'b1, AW'(0), 32'h1234, 1'b1, AW'(0), AW'(0), AW'(0));
        check("t2_x0_data", {32'd0, bus.read_data1}, 64'd0);
        check("t2_x0_busy", {63'd0, bus.read_busy2}, 64'd0);

        // Reserve x7, then write it: busy clears, data lands.
        cyc(1'b0, 1'b0, '0, '0, 1'b1, AW'(7), AW'(7), AW'(7));
        check("t3_busy", {63'd0, bus.read_busy2}, 64'd1);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, AW'(7), AW'(7), AW'(7));
        check("t3_busy_again", {63'd0, bus.read_busy1}, 64'd1);
        cyc(1'b0, 1'b1, AW'(7), 32'h55, 1'b0, '0, AW'(7), AW'(7));
        check("t3_busy_clr", {63'd0, bus.read_busy2}, 64'd0);
        check("t3_data", {32'd0, bus.read_data2}, 64'h55);

        // Same-cycle reserve and write of x9: data written, reserve wins.
        cyc(1'b0, 1'b1, AW'(9), 32'hAA, 1'b1, AW'(9), AW'(9), AW'(9));
        check("t4_data", {32'd0, bus.read_data1}, 64'hAA);
        check("t4_busy", {63'd0, bus.read_busy1}, 64'd1);

        // Write x3 while reading it (same-cycle value checked inside cyc).
        cyc(1'b0, 1'b1, AW'(3), 32'h11, 1'b0, '0, AW'(3), AW'(4));
        cyc(1'b0, 1'b1, AW'(3), 32'h77, 1'b0, '0, AW'(3), AW'(3));
        check("t5_after", {32'd0, bus.read_data2}, 64'h77);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) cyc_rand(1'($urandom_range(0, 249) == 0));
        while (!m_ready) idle(1'b0);

        // Reset pulse in the middle of the sweep restarts it from zero.
        cyc(1'b0, 1'b1, AW'(5), 32'h5555, 1'b0, '0, AW'(5), AW'(5));
        check("t6_x5_set", {32'd0, bus.read_data1}, 64'h5555);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, AW'(5), AW'(5));
        for (int i = 0; i < 10; i++) idle(1'b0);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, AW'(5), AW'(5));
        for (int i = 0; i < NUM_REGS; i++) cyc_rand(1'b0);
        check("t6_still_low", {63'd0, bus.ready}, 64'd0);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, AW'(5), AW'(5));
        check("t6_ready_high", {63'd0, bus.ready}, 64'd1);
        check("t6_x5_zero", {31'd0, bus.read_busy1, bus.read_data1}, 64'd0);

        for (int i = 0; i < 200; i++) cyc_rand(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
